// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready streaming and saturating error counters.
// Optional out_syndrome port ({q, s}) is enabled by defining HAMMING_SYND_OUT_EN.
module hamming_secded_decoder #(
    parameter int unsigned P_BITS    = 3,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned N        = (2 ** P_BITS) - 1,
    localparam int unsigned CW       = N + 1,
    localparam int unsigned K        = N - P_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K-1:0]         out_data,
    output logic                 out_corrected,
    output logic                 out_dbl_err,
`ifdef HAMMING_SYND_OUT_EN
    output logic [P_BITS:0]      out_syndrome,
`endif
    input  logic                 clr_cnt,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] dbl_cnt
);

    // Syndrome equals the XOR of the indices of all set bits in positions 1..N.
    function automatic logic [P_BITS-1:0] calc_syn(input logic [CW-1:0] c);
        logic [P_BITS-1:0] s;
        s = '0;
        for (int j = 1; j <= int'(N); j++) begin
            if (((c >> j) & CW'(1)) != '0) begin
                s = s ^ P_BITS'(j);
            end
        end
        return s;
    endfunction

    // Data bits live at the non-power-of-two positions from 3 upward, data[0] first.
    function automatic logic [K-1:0] extract(input logic [CW-1:0] c);
        logic [K-1:0] d;
        int           idx;
        d   = '0;
        idx = 0;
        for (int j = 3; j <= int'(N); j++) begin
            if ((j & (j - 1)) != 0) begin
                d   = d | (K'(|((c >> j) & CW'(1))) << idx);
                idx = idx + 1;
            end
        end
        return d;
    endfunction

    logic                s1_valid;
    logic [CW-1:0]       s1_code;
    logic [P_BITS-1:0]   s1_syn;
    logic                s1_q;

    logic                adv_c;
    logic [CW-1:0]       fix_code_c;
    logic                corr_c;
    logic                dbl_c;
    logic                out_fire_c;

    assign adv_c      = !out_valid || out_ready;
    assign in_ready   = !s1_valid || adv_c;
    assign out_fire_c = out_valid && out_ready;

    // Stage 1: syndrome and overall parity, raw codeword carried along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_q     <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= calc_syn(in_code);
                s1_q    <= ^in_code;
            end
        end
    end

    // Classification and single-bit correction.
    always_comb begin
        fix_code_c = s1_code;
        corr_c     = 1'b0;
        dbl_c      = 1'b0;
        if (s1_q) begin
            corr_c = 1'b1;
            if (s1_syn != '0) begin
                fix_code_c = s1_code ^ (CW'(1) << s1_syn);
            end
        end else if (s1_syn != '0) begin
            dbl_c = 1'b1;
        end
    end

    // Stage 2: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_corrected <= 1'b0;
            out_dbl_err   <= 1'b0;
        end else if (adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data      <= extract(fix_code_c);
                out_corrected <= corr_c;
                out_dbl_err   <= dbl_c;
            end
        end
    end

`ifdef HAMMING_SYND_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_syndrome <= '0;
        end else if (adv_c && s1_valid) begin
            out_syndrome <= {s1_q, s1_syn};
        end
    end
`endif

    // Saturating statistics on delivered words; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt <= '0;
            dbl_cnt  <= '0;
        end else if (clr_cnt) begin
            corr_cnt <= '0;
            dbl_cnt  <= '0;
        end else if (out_fire_c) begin
            if (out_corrected && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + CNT_WIDTH'(1);
            end
            if (out_dbl_err && (dbl_cnt != '1)) begin
                dbl_cnt <= dbl_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder: directed vectors plus randomized streaming
// against a behavioural model that knows the original data and the injected error count.
module tb_hamming_secded_decoder;

    localparam int unsigned P    = 3;
    localparam int unsigned N    = 7;
    localparam int unsigned CW   = 8;
    localparam int unsigned K    = 4;
    localparam int unsigned CNTW = 2;
    localparam int          CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   in_code = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [K-1:0]    out_data;
    logic            out_corrected;
    logic            out_dbl_err;
    logic            clr_cnt = 1'b0;
    logic [CNTW-1:0] corr_cnt;
    logic [CNTW-1:0] dbl_cnt;
`ifdef HAMMING_SYND_OUT_EN
    logic [P:0]      out_syndrome;
`endif

    hamming_secded_decoder #(.P_BITS(P), .CNT_WIDTH(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_corrected(out_corrected), .out_dbl_err(out_dbl_err),
`ifdef HAMMING_SYND_OUT_EN
        .out_syndrome(out_syndrome),
`endif
        .clr_cnt(clr_cnt), .corr_cnt(corr_cnt), .dbl_cnt(dbl_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [K-1:0] data;
        logic         corr;
        logic         dbl;
    } exp_t;

    exp_t         q[$];
    int           nvec = 0;
    int           nfail = 0;
    int           ndeliv = 0;
    int           mc = 0;
    int           md = 0;
    logic [K-1:0] cur_data = '0;
    int           cur_nerr = 0;
    logic         hold = 1'b0;
    exp_t         held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_pow2(input int j);
        return (j & (j - 1)) == 0;
    endfunction

    // Place data at non-power-of-two positions, then fill parity groups and overall parity.
    function automatic logic [CW-1:0] encode(input logic [K-1:0] d);
        logic [CW-1:0] c;
        logic          p;
        int            idx;
        c   = '0;
        idx = 0;
        for (int j = 3; j <= 7; j++) begin
            if (!is_pow2(j)) begin
                c[3'(j)] = d[2'(idx)];
                idx++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int j = 1; j <= 7; j++) begin
                if (((j >> k) & 1) == 1) p = p ^ c[3'(j)];
            end
            c[3'(1 << k)] = p;
        end
        c[0] = ^c[7:1];
        return c;
    endfunction

    function automatic logic [K-1:0] extract_m(input logic [CW-1:0] c);
        logic [K-1:0] d;
        int           idx;
        d   = '0;
        idx = 0;
        for (int j = 3; j <= 7; j++) begin
            if (!is_pow2(j)) begin
                d[2'(idx)] = c[3'(j)];
                idx++;
            end
        end
        return d;
    endfunction

    // Compare process: checks every cycle against the queue model, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            mc   = 0;
            md   = 0;
            hold = 1'b0;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_corr_cnt", 32'(corr_cnt), 0);
            chk("rst_dbl_cnt", 32'(dbl_cnt), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
        end else begin
            chk("corr_cnt", 32'(corr_cnt), 32'(mc));
            chk("dbl_cnt", 32'(dbl_cnt), 32'(md));
            chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
            if (q.size() == 0) chk("no_stale_valid", 32'(out_valid), 0);
            if (hold) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(held.data));
                chk("stall_corr", 32'(out_corrected), 32'(held.corr));
                chk("stall_dbl", 32'(out_dbl_err), 32'(held.dbl));
            end
            if (out_valid && q.size() != 0) begin
                e = q[0];
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_corrected", 32'(out_corrected), 32'(e.corr));
                chk("out_dbl_err", 32'(out_dbl_err), 32'(e.dbl));
                if (clr_cnt) begin
                    mc = 0;
                    md = 0;
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    ndeliv++;
                    if (!clr_cnt && e.corr && mc < CMAX) mc++;
                    if (!clr_cnt && e.dbl && md < CMAX) md++;
                end
                hold = !out_ready;
                held = e;
            end else begin
                if (clr_cnt) begin
                    mc = 0;
                    md = 0;
                end
                hold = 1'b0;
            end
            if (in_valid && in_ready) begin
                e.corr = (cur_nerr == 1);
                e.dbl  = (cur_nerr == 2);
                e.data = (cur_nerr == 2) ? extract_m(in_code) : cur_data;
                q.push_back(e);
            end
        end
    end

    // Single directed word, unstalled, with literal expectations for latency, outputs and counters.
    task automatic dir(input string name, input logic [CW-1:0] code, input int nerr,
                       input logic [K-1:0] xd, input logic xc, input logic xb,
                       input logic clr, input int xmc, input int xmd);
        @(posedge clk); #1;
        in_code  = code;
        cur_data = 4'hB;
        cur_nerr = nerr;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({name, "_lat1_valid"}, 32'(out_valid), 0);
        @(posedge clk); #1;
        clr_cnt = clr;
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 1);
        chk({name, "_data"}, 32'(out_data), 32'(xd));
        chk({name, "_corr"}, 32'(out_corrected), 32'(xc));
        chk({name, "_dbl"}, 32'(out_dbl_err), 32'(xb));
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        chk({name, "_corr_cnt"}, 32'(corr_cnt), 32'(xmc));
        chk({name, "_dbl_cnt"}, 32'(dbl_cnt), 32'(xmd));
    endtask

    task automatic gen_word();
        logic [K-1:0]  d;
        logic [CW-1:0] c;
        int            p1;
        int            p2;
        d  = K'($urandom);
        c  = encode(d);
        cur_nerr = $urandom_range(0, 2);
        p1 = $urandom_range(0, 7);
        p2 = (p1 + $urandom_range(1, 7)) % 8;
        if (cur_nerr >= 1) c = c ^ (CW'(1) << p1);
        if (cur_nerr == 2) c = c ^ (CW'(1) << p2);
        cur_data = d;
        in_code  = c;
    endtask

    // mode 0: back-to-back with out_ready pattern 1,0,0,1; mode 1: random gaps, ready and clears.
    task automatic stream(input int nw, input int mode);
        int sent;
        int cyc;
        int d0;
        bit acc;
        sent = 0;
        cyc  = 0;
        acc  = 0;
        d0   = ndeliv;
        in_valid = 1'b0;
        while (cyc < 20 * nw + 50) begin
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            if (sent >= nw && q.size() == 0) break;
            out_ready = (mode == 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : ($urandom_range(0, 2) != 0);
            clr_cnt   = (mode == 1) && ($urandom_range(0, 15) == 0);
            if (!in_valid && sent < nw && (mode == 0 || $urandom_range(0, 3) != 0)) begin
                gen_word();
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            cyc++;
        end
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        chk("stream_drained", 32'(sent >= nw && q.size() == 0), 1);
        chk("stream_delivered", 32'(ndeliv - d0), 32'(nw));
    endtask

    initial begin
        logic [CW-1:0] c;
        chk("model_encode_B", 32'(encode(4'hB)), 32'h0000_00AA);
        chk("model_extract_AC", 32'(extract_m(8'hAC)), 32'hB);
        repeat (3) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;

        dir("clean_AA", 8'hAA, 0, 4'hB, 1'b0, 1'b0, 1'b0, 0, 0);
        dir("bit5_8A", 8'h8A, 1, 4'hB, 1'b1, 1'b0, 1'b0, 1, 0);
        dir("bit0_AB", 8'hAB, 1, 4'hB, 1'b1, 1'b0, 1'b0, 2, 0);
        dir("dbl_AC", 8'hAC, 2, 4'hB, 1'b0, 1'b1, 1'b0, 2, 1);
        dir("clr_clean", 8'hAA, 0, 4'hB, 1'b0, 1'b0, 1'b1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            c = 8'hAA ^ (CW'(1) << i);
            dir("sat_single", c, 1, 4'hB, 1'b1, 1'b0, 1'b0, (i < 3) ? i : 3, 0);
        end
        dir("clr_vs_inc", 8'hAA ^ 8'h40, 1, 4'hB, 1'b1, 1'b0, 1'b1, 0, 0);
        dir("dbl_again", 8'hAC, 2, 4'hB, 1'b0, 1'b1, 1'b0, 0, 1);

        stream(8, 0);

        // Two words in flight, consumer stalled, then asynchronous reset.
        @(posedge clk); #1;
        out_ready = 1'b0;
        gen_word();
        in_valid = 1'b1;
        @(posedge clk); #1;
        gen_word();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_inflight", 32'(q.size()), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_corr_cnt", 32'(corr_cnt), 0);
        chk("async_rst_dbl_cnt", 32'(dbl_cnt), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        stream(400, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Pipelined, parametrised extended-Hamming (SECDED) decoder for codewords produced by the team's Hamming generator layout.
- Checks each codeword, corrects single-bit errors, flags double-bit errors and extracts the data bits.
- Valid/ready streaming on both sides; throughput 1 word/cycle, 2-cycle latency; saturating error statistics.
- Sits on the receive side of any protected link or storage path.

Parameters:
- P_BITS, 3, number of Hamming parity bits; N = 2^P_BITS - 1, codeword width N+1, data width K = N - P_BITS (legal: 2..6).
- CNT_WIDTH, 16, width of each saturating error counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  codeword present
- in_ready  output  1  decoder accepts codeword this cycle
- in_code  input  N+1  received codeword
- out_valid  output  1  decoded word present
- out_ready  input  1  consumer accepts word
- out_data  output  K  extracted (corrected) data
- out_corrected  output  1  single-bit error corrected in this word
- out_dbl_err  output  1  uncorrectable double-bit error in this word
- clr_cnt  input  1  synchronous clear of both counters
- corr_cnt  output  CNT_WIDTH  count of delivered corrected words
- dbl_cnt  output  CNT_WIDTH  count of delivered double-error words

Behaviour:
- Codeword layout: bit 0 = overall parity (XOR of bits 1..N); bit 2^(k-1), k=1..P_BITS, = XOR of all positions j in 1..N with bit k-1 of j set; data bits occupy the remaining positions 3..N in ascending order, data[0] at position 3.
- Stage 1 (registered): syndrome s[P_BITS-1:0], bit k-1 = XOR of positions j (incl. 2^(k-1)) with bit k-1 of j set; q = XOR of all N+1 bits; raw codeword carried along.
- Stage 2 (registered outputs), classification:
  - s==0, q==0: clean; both flags 0.
  - q==1, s==0: error in bit 0; data unchanged; out_corrected=1.
  - q==1, s!=0: flip codeword bit s, then extract; out_corrected=1.
  - q==0, s!=0: out_dbl_err=1; out_data = uncorrected extracted data.
- Handshake: word transfers on valid&&ready. Stage 2 loads when !out_valid || out_ready. Stage 1 advances into stage 2 under the same condition. in_ready = !s1_valid || (!out_valid || out_ready); combinational from out_ready, no combinational path from in_valid.
- Latency: word accepted at cycle T appears on out_* at cycle T+2 when unstalled. No loss or duplication under any stall pattern. out_* are held stable while out_valid && !out_ready.
- Counters: increment on out handshake of a word with the corresponding flag; saturate at all-ones (no wrap). clr_cnt wins over a same-cycle increment (result 0).
- Reset: out_valid, internal valids, out_data, flags and both counters go to 0 immediately. Any in-flight words are discarded. in_ready is 1 after reset.

Optional Feature:
- Macro HAMMING_SYND_OUT_EN.
- Defined: adds output port out_syndrome (P_BITS+1 bits = {q, s}), registered alongside out_data; reset value 0.
- Undefined: port absent; no syndrome storage in stage 2; all other behaviour identical.

Test Plan:
- P_BITS=3; in_code=8'hAA, out_ready=1 -> after 2 cycles out_data=4'hB, both flags 0, counters unchanged.
- in_code=8'h8A (bit 5 flipped) -> out_data=4'hB, out_corrected=1, corr_cnt +1. in_code=8'hAB (bit 0 flipped) -> out_data=4'hB, out_corrected=1.
- in_code=8'hAC (bits 1,2 flipped) -> out_dbl_err=1, out_data=4'hB, out_corrected=0, dbl_cnt +1.
- Stream 8 words back-to-back with out_ready toggling 1,0,0,1,... -> all 8 delivered in order, none lost or duplicated, outputs stable during stalls, in_ready low only when both stages are full and out_ready=0.
- CNT_WIDTH=2: deliver 5 single-error words -> corr_cnt sticks at 3. Assert clr_cnt on the cycle of a 6th corrected handshake -> corr_cnt=0.
- Assert rst_n=0 with two words in flight -> out_valid=0 and counters 0 immediately. After release, no stale word is ever emitted.
